// File: rtl/logic_unit_responder.sv
// Bitwise logic unit behind valid/ready handshakes, with a small FIFO response buffer.
// Define LOGIC_OP_COUNT_EN to add op_count, a saturating count of accepted requests.
module logic_unit_responder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ones,
    output logic             busy
`ifdef LOGIC_OP_COUNT_EN
    ,
    output logic [15:0]      op_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_zero;
    logic [DEPTH-1:0] r_ones;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_res;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;

    assign w_empty   = (r_count == '0);
    // req_ready looks only at registered occupancy, so a pop never frees a slot same-cycle
    assign req_ready = rst_n && (r_count < CW'(DEPTH));
    assign w_push    = req_valid && req_ready;
    assign w_pop     = !w_empty && rsp_ready;
    assign rsp_valid = !w_empty;
    assign busy      = !w_empty;
    assign rsp_data  = w_empty ? '0   : r_data[r_rptr];
    assign rsp_zero  = w_empty ? 1'b0 : r_zero[r_rptr];
    assign rsp_ones  = w_empty ? 1'b0 : r_ones[r_rptr];

    always_comb begin
        w_res = '0;
        case (req_op)
            3'b000:  w_res = req_a & req_b;
            3'b001:  w_res = ~(req_a & req_b);
            3'b010:  w_res = req_a | req_b;
            3'b011:  w_res = ~(req_a | req_b);
            3'b100:  w_res = req_a ^ req_b;
            3'b101:  w_res = ~(req_a ^ req_b);
            3'b110:  w_res = ~req_a;
            default: w_res = req_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_zero  <= '0;
            r_ones  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_res;
                r_zero[r_wptr] <= (w_res == '0);
                r_ones[r_wptr] <= &w_res;
                r_wptr         <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef LOGIC_OP_COUNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_push && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
